pc_sequencer: RTL and testbench

Fetch-address controller that sequences the program counter of the single-cycle/pipelined CPU. It selects each next PC from sequential, branch and jump sources. It freezes the PC and raises a pipeline stall while instruction or data memory is busy, and holds any redirect that arrives during a stall until the stall ends. It also flushes the wrong-path instruction after a redirect and flags stalls that run too long.

---
 rtl/pc_sequencer.sv | 152 +++++++++++++++
 tb/tb_pc_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-address controller: picks next PC (sequential/branch/jump), freezes on memory busy,
// holds redirects seen during a stall, flushes wrong-path fetch and flags over-long stalls.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        imem_busy,
  input  logic        dmem_busy,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        stall,
  output logic        flush,
  output logic        misaligned,
  output logic        stall_timeout
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [15:0] LIMIT = 16'(STALL_LIMIT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        flush_q, flush_d;
  logic        misaligned_q, misaligned_d;
  logic        stall_timeout_q, stall_timeout_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic        busy;
  logic        redir;
  logic [31:0] redir_tgt;
  logic        load;
  logic [31:0] load_tgt;
  logic [15:0] stall_cnt_inc;

  assign busy          = imem_busy | dmem_busy;
  assign redir         = jump | branch_taken;
  assign redir_tgt     = jump ? jump_target : branch_target;
  assign stall_cnt_inc = (stall_cnt_q == LIMIT) ? stall_cnt_q : stall_cnt_q + 16'd1;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q         <= BOOT;
      pc_q            <= RESET_PC;
      pc_plus4_q      <= RESET_PC + 32'd4;
      flush_q         <= 1'b0;
      misaligned_q    <= 1'b0;
      stall_timeout_q <= 1'b0;
      pend_vld_q      <= 1'b0;
      pend_tgt_q      <= 32'd0;
      stall_cnt_q     <= 16'd0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pc_plus4_q      <= pc_plus4_d;
      flush_q         <= flush_d;
      misaligned_q    <= misaligned_d;
      stall_timeout_q <= stall_timeout_d;
      pend_vld_q      <= pend_vld_d;
      pend_tgt_q      <= pend_tgt_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = busy ? STALL : RUN;
      STALL:   state_d = busy ? STALL : RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d            = pc_q;
    pend_vld_d      = pend_vld_q;
    pend_tgt_d      = pend_tgt_q;
    stall_cnt_d     = stall_cnt_q;
    stall_timeout_d = stall_timeout_q;
    load            = 1'b0;
    load_tgt        = pc_q;

    case (state_q)
      RUN: begin
        stall_cnt_d = 16'd0;
        if (busy) begin
          if (redir) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = redir_tgt;
          end
        end else if (redir) begin
          load     = 1'b1;
          load_tgt = redir_tgt;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      STALL: begin
        stall_cnt_d = stall_cnt_inc;
        if (stall_cnt_inc == LIMIT) begin
          stall_timeout_d = 1'b1;
        end
        if (redir) begin
          pend_vld_d = 1'b1;
          pend_tgt_d = redir_tgt;
        end
        // A redirect arriving in the release cycle is the latest capture, so it wins.
        if (!busy) begin
          stall_cnt_d = 16'd0;
          pend_vld_d  = 1'b0;
          if (redir || pend_vld_q) begin
            load     = 1'b1;
            load_tgt = redir ? redir_tgt : pend_tgt_q;
          end
        end
      end
      default: ;
    endcase

    if (load) begin
      pc_d = {load_tgt[31:2], 2'b00};
    end
    flush_d      = load;
    misaligned_d = load && (load_tgt[1:0] != 2'b00);
    pc_plus4_d   = pc_d + 32'd4;
  end

  always_comb begin
    pc            = pc_q;
    pc_plus4      = pc_plus4_q;
    flush         = flush_q;
    misaligned    = misaligned_q;
    stall_timeout = stall_timeout_q;
    fetch_valid   = (state_q == RUN);
    stall         = busy | (state_q != RUN);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (RESET_PC=0/LIMIT=255 and RESET_PC=FFFF_FFF8/LIMIT=4)
// share stimulus; a per-cycle model comparison plus directed literal expectations.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        imem_busy, dmem_busy, branch_taken, jump;
  logic [31:0] branch_target, jump_target;

  logic [31:0] pc_o [2];
  logic [31:0] pc_plus4_o [2];
  logic        fv_o [2];
  logic        stall_o [2];
  logic        flush_o [2];
  logic        mis_o [2];
  logic        to_o [2];

  int n_pass = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .STALL_LIMIT(255)) dut_a (
    .CLK(CLK), .RESET(RESET), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .pc(pc_o[0]), .pc_plus4(pc_plus4_o[0]), .fetch_valid(fv_o[0]), .stall(stall_o[0]),
    .flush(flush_o[0]), .misaligned(mis_o[0]), .stall_timeout(to_o[0])
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFF8), .STALL_LIMIT(4)) dut_b (
    .CLK(CLK), .RESET(RESET), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .pc(pc_o[1]), .pc_plus4(pc_plus4_o[1]), .fetch_valid(fv_o[1]), .stall(stall_o[1]),
    .flush(flush_o[1]), .misaligned(mis_o[1]), .stall_timeout(to_o[1])
  );

  // Behavioural model: "booted" and "stalled" flags, a latest-wins pending slot, an unbounded stall tally.
  logic [31:0] m_rpc [2] = '{32'h0000_0000, 32'hFFFF_FFF8};
  int          m_limit [2] = '{255, 4};
  logic [31:0] m_pc [2];
  bit          m_booted [2], m_stalled [2], m_pend [2], m_flush [2], m_mis [2], m_to [2];
  logic [31:0] m_pend_tgt [2];
  int          m_stall_cycles [2];

  task automatic m_load(input int k, input logic [31:0] t);
    m_pc[k]    = t & 32'hFFFF_FFFC;
    m_flush[k] = 1'b1;
    m_mis[k]   = (t % 4) != 0;
  endtask

  always @(posedge CLK or negedge RESET) begin
    for (int k = 0; k < 2; k++) begin
      if (!RESET) begin
        m_pc[k] = m_rpc[k]; m_booted[k] = 0; m_stalled[k] = 0; m_pend[k] = 0;
        m_pend_tgt[k] = 0; m_flush[k] = 0; m_mis[k] = 0; m_to[k] = 0; m_stall_cycles[k] = 0;
      end else begin
        bit          busy, redir;
        logic [31:0] tgt;
        busy  = imem_busy || dmem_busy;
        redir = jump || branch_taken;
        tgt   = jump ? jump_target : branch_target;
        m_flush[k] = 0;
        m_mis[k]   = 0;
        if (!m_booted[k]) begin
          m_booted[k] = 1;
        end else if (!m_stalled[k]) begin
          if (busy) begin
            m_stalled[k] = 1;
            m_stall_cycles[k] = 0;
            if (redir) begin m_pend[k] = 1; m_pend_tgt[k] = tgt; end
          end else if (redir) begin
            m_load(k, tgt);
          end else begin
            m_pc[k] = m_pc[k] + 32'd4;
          end
        end else begin
          m_stall_cycles[k]++;
          if (m_stall_cycles[k] >= m_limit[k]) m_to[k] = 1;
          if (redir) begin m_pend[k] = 1; m_pend_tgt[k] = tgt; end
          if (!busy) begin
            m_stalled[k] = 0;
            if (m_pend[k]) m_load(k, m_pend_tgt[k]);
            m_pend[k] = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("m_pc%0d", k), pc_o[k], m_pc[k]);
      chk($sformatf("m_pc4_%0d", k), pc_plus4_o[k], m_pc[k] + 32'd4);
      chk($sformatf("m_fv%0d", k), 32'(fv_o[k]), 32'(m_booted[k] && !m_stalled[k]));
      chk($sformatf("m_stall%0d", k), 32'(stall_o[k]),
          32'(imem_busy || dmem_busy || !m_booted[k] || m_stalled[k]));
      chk($sformatf("m_flush%0d", k), 32'(flush_o[k]), 32'(m_flush[k]));
      chk($sformatf("m_mis%0d", k), 32'(mis_o[k]), 32'(m_mis[k]));
      chk($sformatf("m_to%0d", k), 32'(to_o[k]), 32'(m_to[k]));
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit ib, input bit db, input bit br, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt);
    imem_busy = ib; dmem_busy = db; branch_taken = br; branch_target = bt;
    jump = j; jump_target = jt;
  endtask

  initial begin
    RESET = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_pc_a", pc_o[0], 32'h0);
    chk("rst_pc_b", pc_o[1], 32'hFFFF_FFF8);
    chk("rst_fv", 32'(fv_o[0]), 0);
    RESET = 1'b1;
    #1;
    chk("boot_stall", 32'(stall_o[0]), 1);
    chk("boot_fv", 32'(fv_o[0]), 0);
    chk("boot_pc", pc_o[0], 32'h0);
    tick;
    chk("run_pc0", pc_o[0], 32'h0);
    chk("run_fv", 32'(fv_o[0]), 1);
    chk("wrap_b0", pc_o[1], 32'hFFFF_FFF8);
    tick;
    chk("seq_pc4", pc_o[0], 32'h4);
    chk("wrap_b1", pc_o[1], 32'hFFFF_FFFC);
    tick;
    chk("seq_pc8", pc_o[0], 32'h8);
    chk("wrap_b2", pc_o[1], 32'h0000_0000);
    tick;
    chk("seq_pc12", pc_o[0], 32'hC);

    // Timeout on the LIMIT=4 instance, then async reset mid-stall with a redirect pending.
    drive(1, 0, 0, 0, 0, 0);
    repeat (4) tick;
    chk("to_before", 32'(to_o[1]), 0);
    tick;
    chk("to_set", 32'(to_o[1]), 1);
    drive(1, 0, 1, 32'h300, 0, 0);
    tick;
    drive(1, 0, 0, 0, 0, 0);
    tick;
    chk("to_sticky", 32'(to_o[1]), 1);
    chk("to_a_clear", 32'(to_o[0]), 0);
    chk("stall_hold_pc", pc_o[0], 32'hC);
    #3 RESET = 1'b0;
    #1;
    chk("arst_pc_a", pc_o[0], 32'h0);
    chk("arst_pc_b", pc_o[1], 32'hFFFF_FFF8);
    chk("arst_to", 32'(to_o[1]), 0);
    chk("arst_fv", 32'(fv_o[0]), 0);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    #1 RESET = 1'b1;
    tick;
    chk("reboot_pc", pc_o[0], 32'h0);
    tick;
    chk("pend_cleared", pc_o[0], 32'h4);
    repeat (3) tick;
    chk("at_0x10", pc_o[0], 32'h10);

    // Jump beats branch.
    drive(0, 0, 1, 32'h40, 1, 32'h80);
    tick;
    chk("jmp_pc", pc_o[0], 32'h80);
    chk("jmp_flush", 32'(flush_o[0]), 1);
    drive(0, 0, 0, 0, 0, 0);
    tick;
    chk("jmp_next", pc_o[0], 32'h84);
    chk("jmp_flush_end", 32'(flush_o[0]), 0);

    // Stall with a branch captured on the second stall cycle.
    drive(0, 0, 0, 0, 1, 32'h20);
    tick;
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("stl_stall1", 32'(stall_o[0]), 1);
    tick;
    drive(1, 0, 1, 32'h100, 0, 0);
    tick;
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) tick;
    chk("stl_pc_hold", pc_o[0], 32'h20);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("stl_stall_rel", 32'(stall_o[0]), 1);
    tick;
    chk("stl_redir", pc_o[0], 32'h100);
    chk("stl_flush", 32'(flush_o[0]), 1);
    tick;
    chk("stl_after", pc_o[0], 32'h104);
    chk("stl_flush_end", 32'(flush_o[0]), 0);

    // Misaligned jump target.
    drive(0, 0, 0, 0, 1, 32'h203);
    tick;
    chk("mis_pc", pc_o[0], 32'h200);
    chk("mis_pulse", 32'(mis_o[0]), 1);
    drive(0, 0, 0, 0, 0, 0);
    tick;
    chk("mis_end", 32'(mis_o[0]), 0);
    chk("mis_next", pc_o[0], 32'h204);

    // Stall without redirect re-issues the held fetch.
    drive(0, 0, 0, 0, 1, 32'h2C);
    tick;
    drive(0, 0, 0, 0, 0, 0);
    tick;
    chk("nr_pc", pc_o[0], 32'h30);
    drive(0, 1, 0, 0, 0, 0);
    repeat (2) tick;
    chk("nr_hold", pc_o[0], 32'h30);
    drive(0, 0, 0, 0, 0, 0);
    tick;
    chk("nr_reissue", pc_o[0], 32'h30);
    chk("nr_fv", 32'(fv_o[0]), 1);
    chk("nr_noflush", 32'(flush_o[0]), 0);
    tick;
    chk("nr_adv", pc_o[0], 32'h34);
    chk("nr_noflush2", 32'(flush_o[0]), 0);

    repeat (2) tick;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
